ncc_feeder: RTL and testbench

Producer side of the NCC core's descriptor and window load interfaces. It streams a 256-pixel descriptor into the core as 64 packed 32-bit beats, then buffers a search region. From that region it presents every 16x16 window position, one at a time, to the core's window handshake. It sits between the host/frame-buffer byte streams and the NCC core, and signals when the whole search has been correlated.

---
 rtl/ncc_feeder.sv | 138 +++++++++++++
 tb/tb_ncc_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_feeder.sv
// rtl/ncc_feeder.sv - NCC core feeder: descriptor stream, search-region buffer, window presenter
module ncc_feeder #(
  parameter int POS_X      = 10,
  parameter int POS_Y      = 15,
  parameter int DESC_WORDS = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   start_keep_desc,
  input  logic                   desc_in_valid,
  output logic                   desc_in_ready,
  input  logic [31:0]            desc_in_word,
  input  logic                   pix_in_valid,
  output logic                   pix_in_ready,
  input  logic [7:0]             pix_in_data,
  output logic [31:0]            desc_data_out,
  output logic                   desc_data_ready,
  output logic [15:0][15:0][7:0] window_data_out,
  output logic                   window_data_ready,
  input  logic                   done_with_window_data,
  output logic [8:0]             window_index,
  output logic                   busy,
  output logic                   search_done
);
  localparam int W    = POS_X + 15;
  localparam int H    = POS_Y + 15;
  localparam int NPIX = W * H;
  localparam int NWIN = POS_X * POS_Y;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(DESC_WORDS);
  localparam int XW   = $clog2(POS_X);
  localparam int YW   = $clog2(POS_Y);

  typedef enum logic [2:0] {IDLE, LOAD_DESC, LOAD_REGION, FETCH, PRESENT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          word_cnt_q;
  logic [AW-1:0]          pix_cnt_q;
  logic [XW-1:0]          wx_q;
  logic [YW-1:0]          wy_q;
  logic [31:0]            desc_q;
  logic                   desc_rdy_q;
  logic [15:0][15:0][7:0] win_q;
  logic [8:0]             win_idx_q;
  logic [7:0]             region_q [NPIX];

  logic          desc_acc, pix_acc, win_ack;
  logic          last_word, last_pix, last_win, last_col;
  logic [AW-1:0] win_base;

  assign desc_in_ready     = (state_q == LOAD_DESC);
  assign pix_in_ready      = (state_q == LOAD_REGION);
  assign window_data_ready = (state_q == PRESENT);
  assign busy              = (state_q != IDLE);
  assign search_done       = (state_q == DONE);
  assign desc_data_out     = desc_q;
  assign desc_data_ready   = desc_rdy_q;
  assign window_data_out   = win_q;
  assign window_index      = win_idx_q;

  assign desc_acc  = desc_in_ready & desc_in_valid;
  assign pix_acc   = pix_in_ready & pix_in_valid;
  assign win_ack   = window_data_ready & done_with_window_data;
  assign last_word = (word_cnt_q == CW'(DESC_WORDS - 1));
  assign last_pix  = (pix_cnt_q == AW'(NPIX - 1));
  assign last_win  = (win_idx_q == 9'(NWIN - 1));
  assign last_col  = (wx_q == XW'(POS_X - 1));
  assign win_base  = AW'(wy_q) * AW'(W) + AW'(wx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start)                state_d = LOAD_DESC;
        else if (start_keep_desc) state_d = LOAD_REGION;
      end
      LOAD_DESC:   if (desc_acc && last_word) state_d = LOAD_REGION;
      LOAD_REGION: if (pix_acc && last_pix)   state_d = FETCH;
      FETCH:       state_d = PRESENT;
      PRESENT:     if (win_ack) state_d = last_win ? DONE : FETCH;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Region contents carry no reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (pix_acc) region_q[pix_cnt_q] <= pix_in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      pix_cnt_q  <= '0;
      wx_q       <= '0;
      wy_q       <= '0;
      desc_q     <= '0;
      desc_rdy_q <= 1'b0;
      win_q      <= '0;
      win_idx_q  <= '0;
    end else begin
      desc_rdy_q <= desc_acc;
      if (state_q == IDLE) begin
        word_cnt_q <= '0;
        pix_cnt_q  <= '0;
        wx_q       <= '0;
        wy_q       <= '0;
      end
      if (desc_acc) begin
        desc_q     <= desc_in_word;
        word_cnt_q <= word_cnt_q + CW'(1);
      end
      if (pix_acc) pix_cnt_q <= pix_cnt_q + AW'(1);
      if (state_q == FETCH) begin
        for (int i = 0; i < 16; i++) begin
          for (int j = 0; j < 16; j++) begin
            win_q[i][j] <= region_q[win_base + AW'(i * W + j)];
          end
        end
        win_idx_q <= 9'(int'(wy_q) * POS_X + int'(wx_q));
      end
      if (win_ack) begin
        if (last_col) begin
          wx_q <= '0;
          wy_q <= wy_q + YW'(1);
        end else begin
          wx_q <= wx_q + XW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ncc_feeder.sv
// tb/tb_ncc_feeder.sv - directed self-checking bench for ncc_feeder
module tb_ncc_feeder;
  localparam int POS_X = 10;
  localparam int POS_Y = 15;
  localparam int W     = POS_X + 15;
  localparam int NPIX  = W * (POS_Y + 15);
  localparam int NWIN  = POS_X * POS_Y;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start, start_keep_desc;
  logic                   desc_in_valid, desc_in_ready;
  logic [31:0]            desc_in_word;
  logic                   pix_in_valid, pix_in_ready;
  logic [7:0]             pix_in_data;
  logic [31:0]            desc_data_out;
  logic                   desc_data_ready;
  logic [15:0][15:0][7:0] window_data_out;
  logic                   window_data_ready;
  logic                   done_with_window_data;
  logic [8:0]             window_index;
  logic                   busy, search_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, rdy_cnt = 0, first_rdy = 0, last_rdy = 0;
  int desc_in_rdy_cycles = 0, done_pulses = 0;

  ncc_feeder #(.POS_X(POS_X), .POS_Y(POS_Y), .DESC_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_keep_desc(start_keep_desc),
    .desc_in_valid(desc_in_valid), .desc_in_ready(desc_in_ready), .desc_in_word(desc_in_word),
    .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready), .pix_in_data(pix_in_data),
    .desc_data_out(desc_data_out), .desc_data_ready(desc_data_ready),
    .window_data_out(window_data_out), .window_data_ready(window_data_ready),
    .done_with_window_data(done_with_window_data), .window_index(window_index),
    .busy(busy), .search_done(search_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return 32'h00010203 + 32'(k) * 32'h04040404;
  endfunction

  function automatic logic [7:0] exp_px(input int wx, input int wy, input int i, input int j);
    return 8'(((wy + i) * W + wx + j) % 256);
  endfunction

  always @(negedge clk) begin
    if (desc_in_ready) desc_in_rdy_cycles++;
    if (search_done) done_pulses++;
    if (desc_data_ready) begin
      check("desc_data_out", 64'(desc_data_out), 64'(exp_word(rdy_cnt)));
      if (rdy_cnt == 0) first_rdy = cyc;
      last_rdy = cyc;
      rdy_cnt++;
    end
    cyc++;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_desc_in_ready"}, 64'(desc_in_ready), 0);
    check({tag, "_pix_in_ready"}, 64'(pix_in_ready), 0);
    check({tag, "_desc_data_out"}, 64'(desc_data_out), 0);
    check({tag, "_desc_data_ready"}, 64'(desc_data_ready), 0);
    check({tag, "_win_any"}, 64'(|window_data_out), 0);
    check({tag, "_win_ready"}, 64'(window_data_ready), 0);
    check({tag, "_win_index"}, 64'(window_index), 0);
    check({tag, "_search_done"}, 64'(search_done), 0);
  endtask

  task automatic send_desc(input int gap_after);
    for (int k = 0; k < 64; k++) begin
      for (int t = 0; t < 10 && !desc_in_ready; t++) @(negedge clk);
      check("desc_in_ready_wait", 64'(desc_in_ready), 1);
      desc_in_valid = 1'b1;
      desc_in_word  = exp_word(k);
      @(negedge clk);
      desc_in_valid = 1'b0;
      if (k == gap_after) repeat (3) @(negedge clk);
    end
    check("desc_last_pulse", 64'(desc_data_ready), 1);
    check("region_entry", 64'(pix_in_ready), 1);
    check("desc_in_ready_off", 64'(desc_in_ready), 0);
  endtask

  task automatic send_region();
    for (int t = 0; t < 10 && !pix_in_ready; t++) @(negedge clk);
    check("pix_in_ready_wait", 64'(pix_in_ready), 1);
    for (int c = 0; c < NPIX; c++) begin
      pix_in_valid = 1'b1;
      pix_in_data  = 8'(c % 256);
      @(negedge clk);
    end
    pix_in_valid = 1'b0;
    check("fetch_ready_low", 64'(window_data_ready), 0);
    check("fetch_busy", 64'(busy), 1);
    @(negedge clk);
    check("first_window_ready", 64'(window_data_ready), 1);
  endtask

  task automatic run_windows(input int stall_at, input int spur_at, input int start_at, input int abort_at);
    int wx, wy, ci, cj;
    logic [7:0] px0;
    for (int n = 0; n < NWIN; n++) begin
      for (int t = 0; t < 10 && !window_data_ready; t++) @(negedge clk);
      check("window_ready_wait", 64'(window_data_ready), 1);
      wx = n % POS_X;
      wy = n / POS_X;
      ci = n % 16;
      cj = (n * 7) % 16;
      check("window_index", 64'(window_index), 64'(n));
      check("win_px_0_0", 64'(window_data_out[0][0]), 64'(exp_px(wx, wy, 0, 0)));
      check("win_px_15_15", 64'(window_data_out[15][15]), 64'(exp_px(wx, wy, 15, 15)));
      check("win_px_mid", 64'(window_data_out[ci][cj]), 64'(exp_px(wx, wy, ci, cj)));
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (n == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_idx", 64'(window_index), 64'(n));
        check("start_ignored_rdy", 64'(window_data_ready), 1);
        check("start_ignored_desc", 64'(desc_in_ready), 0);
      end
      if (n == stall_at) begin
        px0 = window_data_out[0][0];
        repeat (20) begin
          @(negedge clk);
          check("stall_ready", 64'(window_data_ready), 1);
        end
        check("stall_index", 64'(window_index), 64'(n));
        check("stall_px", 64'(window_data_out[0][0]), 64'(px0));
      end
      done_with_window_data = 1'b1;
      @(negedge clk);
      if (n == NWIN - 1) begin
        done_with_window_data = 1'b0;
        check("search_done_pulse", 64'(search_done), 1);
        check("busy_at_done", 64'(busy), 1);
        @(negedge clk);
        check("search_done_end", 64'(search_done), 0);
        check("busy_after_done", 64'(busy), 0);
      end else begin
        check("turnaround_low", 64'(window_data_ready), 0);
        if (n == spur_at) @(negedge clk);
        done_with_window_data = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_keep_desc = 1'b0;
    desc_in_valid = 1'b0;
    desc_in_word = '0;
    pix_in_valid = 1'b0;
    pix_in_data = '0;
    done_with_window_data = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full search, host gap after word 10, stall and spurious done.
    rdy_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run1_busy", 64'(busy), 1);
    send_desc(10);
    send_region();
    check("run1_desc_count", 64'(rdy_cnt), 64);
    check("run1_desc_span", 64'(last_rdy - first_rdy + 1), 67);
    check("w0_px_15_15", 64'(window_data_out[15][15]), 134);
    run_windows(5, 6, -1, -1);
    check("run1_done_pulses", 64'(done_pulses), 1);

    // Keep descriptor, start ignored while presenting, reset mid-present.
    desc_in_rdy_cycles = 0;
    start_keep_desc = 1'b1;
    @(negedge clk);
    start_keep_desc = 1'b0;
    check("keep_region_entry", 64'(pix_in_ready), 1);
    send_region();
    run_windows(-1, -1, 3, 11);
    check("keep_no_desc_ready", 64'(desc_in_rdy_cycles), 0);
    @(negedge clk);
    check("post_abort_busy", 64'(busy), 0);

    // Clean re-run after reset: start wins over start_keep_desc, back-to-back words.
    rdy_cnt = 0;
    done_pulses = 0;
    start = 1'b1;
    start_keep_desc = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_keep_desc = 1'b0;
    check("start_wins", 64'(desc_in_ready), 1);
    send_desc(-1);
    send_region();
    check("run3_desc_count", 64'(rdy_cnt), 64);
    check("run3_desc_span", 64'(last_rdy - first_rdy + 1), 64);
    run_windows(-1, -1, -1, -1);
    check("run3_done_pulses", 64'(done_pulses), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
